// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  // One buffered instruction, tagged with the address it came from.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // A redirect target is misaligned when its byte offset bits are non-zero.
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries between memory response and decode.
// Flush empties it in one cycle and wins over push/pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge CLK) begin
    if (RESET || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front-end: owns the fetch PC, issues one word-aligned read
// at a time to instruction memory, and buffers returned words toward decode.
//
// Handshakes (request and output channels): a transfer happens on a posedge
// where valid and ready are both high; valid never depends on ready in the
// same cycle, and a raised valid keeps its payload until the transfer occurs
// or a redirect/reset intervenes.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                        CLK,
  input  logic                        RESET,
  output logic                        imem_req_valid,
  input  logic                        imem_req_ready,
  output logic [PC_W-1:0]             imem_req_addr,
  input  logic                        imem_rsp_valid,
  input  logic [INSTR_W-1:0]          imem_rsp_data,
  input  logic                        redirect_valid,
  input  logic [PC_W-1:0]             redirect_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PC_W-1:0]             out_pc,
  output logic [INSTR_W-1:0]          out_instr,
  output logic                        misalign_err,
  output fetch_state_t                state_dbg,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_dbg
);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] req_pc;
  logic [PC_W-1:0] req_pc_next;
  logic            drop_pending;
  logic            drop_next;
  logic            req_fire;

  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  fetch_entry_t                fifo_in;
  fetch_entry_t                fifo_head;

  assign fifo_in.pc    = req_pc;
  assign fifo_in.instr = imem_rsp_data;
  assign fifo_pop      = out_valid && out_ready;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .RESET      (RESET),
    .push       (fifo_push),
    .push_entry (fifo_in),
    .pop        (fifo_pop),
    .flush      (redirect_valid),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head       (fifo_head)
  );

  // Output side: head of the buffer, forced to zero while empty.
  assign out_valid      = !fifo_empty;
  assign out_pc         = fifo_empty ? '0 : fifo_head.pc;
  assign out_instr      = fifo_empty ? '0 : fifo_head.instr;
  assign state_dbg      = state;
  assign fifo_level_dbg = fifo_count;

  // Next-state, request outputs and buffer push; redirect overrides the PC last.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    req_pc_next    = req_pc;
    drop_next      = drop_pending;
    imem_req_valid = 1'b0;
    imem_req_addr  = '0;
    req_fire       = 1'b0;
    fifo_push      = 1'b0;
    case (state)
      IDLE: begin
        state_next = REQ;
      end
      REQ: begin
        // Only ask when there is room: one outstanding request plus a free slot
        // guarantees the response can always be pushed.
        imem_req_valid = !fifo_full;
        imem_req_addr  = pc;
        req_fire       = !fifo_full && imem_req_ready;
        if (req_fire) begin
          req_pc_next = pc;
          pc_next     = pc + PC_INC;
          state_next  = WAIT;
          // A redirect in the accept cycle makes this request stale on arrival.
          drop_next   = redirect_valid;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          fifo_push  = !drop_pending && !redirect_valid;
          drop_next  = 1'b0;
          state_next = REQ;
        end else if (redirect_valid) begin
          drop_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (redirect_valid) begin
      pc_next = {redirect_pc[PC_W-1:2], 2'b00};
    end
  end

  // Sequencer state, fetch PC and redirect error flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      req_pc       <= '0;
      drop_pending <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      req_pc       <= req_pc_next;
      drop_pending <= drop_next;
      misalign_err <= redirect_valid && is_misaligned(redirect_pc[1:0]);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by randomized traffic,
// all checked against a transaction-level scoreboard every cycle.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  logic         imem_req_valid, imem_req_ready;
  logic [31:0]  imem_req_addr;
  logic         imem_rsp_valid;
  logic [31:0]  imem_rsp_data;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         out_valid, out_ready;
  logic [31:0]  out_pc, out_instr;
  logic         misalign_err;
  fetch_state_t state_dbg;
  logic [$clog2(DEPTH):0] fifo_level_dbg;

  instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .misalign_err   (misalign_err),
    .state_dbg      (state_dbg),
    .fifo_level_dbg (fifo_level_dbg)
  );

  // ---------------- stimulus knobs ----------------
  // ready modes: 0 random, 1 high, 2 low; latency 0 means random 1..3
  logic        k_rst = 1'b1;
  int          k_rdy = 1;
  int          k_ordy = 1;
  int          k_lat = 1;
  logic        k_redir = 1'b0;
  logic [31:0] k_rpc = '0;

  // ---------------- memory model ----------------
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_due = 0;
  int          cyc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic        m_out = 1'b0;
  logic [31:0] m_addr = '0;
  logic        m_drop = 1'b0;
  logic [31:0] exp_pc = RPC;
  logic        exp_mis = 1'b0;
  int          since = 0;
  logic [31:0] pop_log[$];
  logic [31:0] req_log[$];
  int          first_req_cyc = -1;
  int          first_out_cyc = -1;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare every DUT output against the scoreboard view of the current cycle.
  task automatic check_outputs();
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("fifo_level", fifo_level_dbg, exp_q.size());
    if (exp_q.size() != 0) begin
      chk("out_pc", out_pc, exp_q[0][63:32]);
      chk("out_instr", out_instr, exp_q[0][31:0]);
    end
    chk("misalign_err", misalign_err, exp_mis);
    chk("req_valid", imem_req_valid, (since >= 1) && !m_out && (exp_q.size() < DEPTH));
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_pc);
    if (since == 0) begin
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_req_addr", imem_req_addr, 0);
      chk("rst_state", state_dbg, IDLE);
    end
    if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
  endtask

  // Advance the scoreboard across the coming clock edge, from the values the DUT sees.
  task automatic model_step();
    logic fire;
    if (RESET) begin
      exp_q.delete();
      m_out = 1'b0; m_drop = 1'b0; exp_pc = RPC; exp_mis = 1'b0;
      since = 0; mem_pend = 1'b0;
      return;
    end
    fire = imem_req_valid && imem_req_ready;
    if (fire) begin
      req_log.push_back(imem_req_addr);
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (exp_q.size() != 0 && out_ready && !redirect_valid) begin
      pop_log.push_back(out_pc);
      void'(exp_q.pop_front());
    end
    if (imem_rsp_valid) begin
      if (!m_drop && !redirect_valid) exp_q.push_back({m_addr, mem_word(m_addr)});
      m_out = 1'b0; m_drop = 1'b0; mem_pend = 1'b0;
    end else if (m_out && redirect_valid) begin
      m_drop = 1'b1;
    end
    if (fire) begin
      m_out = 1'b1; m_addr = exp_pc; m_drop = redirect_valid;
      mem_pend = 1'b1; mem_addr = exp_pc;
      mem_due = cyc + ((k_lat == 0) ? int'($urandom_range(1, 3)) : k_lat);
    end
    if (redirect_valid) begin
      exp_pc = {redirect_pc[31:2], 2'b00};
      exp_q.delete();
    end else if (fire) begin
      exp_pc = exp_pc + 32'd4;
    end
    exp_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
    since++;
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    check_outputs();
    RESET          = k_rst;
    imem_req_ready = (k_rdy == 0) ? 1'($urandom_range(0, 1)) : (k_rdy == 1);
    out_ready      = (k_ordy == 0) ? 1'($urandom_range(0, 1)) : (k_ordy == 1);
    redirect_valid = k_redir;
    redirect_pc    = k_rpc;
    if (mem_pend && cyc >= mem_due) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic do_reset();
    k_rst = 1'b1; k_redir = 1'b0; k_rdy = 1; k_ordy = 1; k_lat = 1;
    repeat (2) cycle();
    k_rst = 1'b0;
    pop_log.delete(); req_log.delete();
    first_req_cyc = -1; first_out_cyc = -1;
    cyc = 0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int mark, rmark;
    logic hit;
    imem_req_ready = 1'b0; out_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge CLK);

    // 1: zero-wait streaming, latency and order
    do_reset();
    for (int i = 0; i < 60 && pop_log.size() < 6; i++) cycle();
    chk("t1_six_pops", pop_log.size() >= 6, 1);
    for (int j = 0; j < 6; j++)
      if (j < pop_log.size()) chk("t1_out_pc", pop_log[j], 32'(4 * j));
    for (int j = 0; j < 6; j++)
      if (j < req_log.size()) chk("t1_req_addr", req_log[j], 32'(4 * j));
    chk("t1_first_req_cyc", first_req_cyc, 1);
    chk("t1_first_out_cyc", first_out_cyc, 3);

    // 2: decode stalled, buffer fills to two then fetch stops
    do_reset();
    k_ordy = 2;
    repeat (10) cycle();
    chk("t2_full_valid", out_valid, 1);
    chk("t2_full_level", fifo_level_dbg, 2);
    chk("t2_head_pc", out_pc, 32'h0);
    chk("t2_no_req", imem_req_valid, 0);
    chk("t2_req_count", req_log.size(), 2);
    k_ordy = 1;
    for (int i = 0; i < 30 && pop_log.size() < 3; i++) cycle();
    chk("t2_drained", pop_log.size() >= 3, 1);
    if (pop_log.size() >= 3) begin
      chk("t2_pop0", pop_log[0], 32'h0);
      chk("t2_pop1", pop_log[1], 32'h4);
      chk("t2_pop2", pop_log[2], 32'h8);
    end

    // 3: memory not ready, request held stable at 0x8
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (imem_req_valid && imem_req_addr == 32'h8) hit = 1'b1;
      else cycle();
    end
    chk("t3_reach_8", hit, 1);
    k_rdy = 2;
    repeat (4) begin
      chk("t3_hold_valid", imem_req_valid, 1);
      chk("t3_hold_addr", imem_req_addr, 32'h8);
      cycle();
    end
    k_rdy = 1;
    for (int i = 0; i < 30 && req_log.size() < 4; i++) cycle();
    chk("t3_reqs", req_log.size() >= 4, 1);
    if (req_log.size() >= 4) begin
      chk("t3_req2", req_log[2], 32'h8);
      chk("t3_req3", req_log[3], 32'hC);
    end

    // 4: redirect to 0x100 while waiting on 0xC
    do_reset();
    k_lat = 3;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      if (imem_req_valid && imem_req_addr == 32'hC) hit = 1'b1;
      else cycle();
    end
    chk("t4_reach_c", hit, 1);
    cycle();
    cycle();
    k_redir = 1'b1; k_rpc = 32'h100;
    mark = pop_log.size(); rmark = req_log.size();
    cycle();
    k_redir = 1'b0;
    chk("t4_flushed", out_valid, 0);
    for (int i = 0; i < 40 && (req_log.size() <= rmark || pop_log.size() <= mark); i++) cycle();
    chk("t4_progress", (req_log.size() > rmark) && (pop_log.size() > mark), 1);
    if (req_log.size() > rmark) chk("t4_next_req", req_log[rmark], 32'h100);
    if (pop_log.size() > mark) chk("t4_next_out", pop_log[mark], 32'h100);

    // 5: misaligned redirect coincident with a response
    do_reset();
    k_lat = 2;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (mem_pend && mem_due <= cyc && mem_addr != 32'h0) hit = 1'b1;
      else cycle();
    end
    chk("t5_reach_rsp", hit, 1);
    k_redir = 1'b1; k_rpc = 32'h203;
    rmark = req_log.size();
    cycle();
    k_redir = 1'b0;
    chk("t5_mis_pulse", misalign_err, 1);
    cycle();
    chk("t5_mis_clear", misalign_err, 0);
    for (int i = 0; i < 20 && req_log.size() <= rmark; i++) cycle();
    if (req_log.size() > rmark) chk("t5_next_req", req_log[rmark], 32'h200);
    else chk("t5_next_req_seen", 0, 1);

    // 6: wrap-around, then reset in the middle of a wait
    do_reset();
    cycle();
    k_redir = 1'b1; k_rpc = 32'hFFFF_FFFC;
    cycle();
    k_redir = 1'b0;
    for (int i = 0; i < 30 && pop_log.size() < 2; i++) cycle();
    chk("t6_two_pops", pop_log.size() >= 2, 1);
    if (pop_log.size() >= 2) begin
      chk("t6_pc_top", pop_log[0], 32'hFFFF_FFFC);
      chk("t6_pc_wrap", pop_log[1], 32'h0);
    end
    k_lat = 3;
    for (int i = 0; i < 20 && !m_out; i++) cycle();
    cycle();
    k_rst = 1'b1;
    cycle();
    k_rst = 1'b0;
    chk("t6_rst_req_valid", imem_req_valid, 0);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_out_pc", out_pc, 0);
    chk("t6_rst_out_instr", out_instr, 0);
    chk("t6_rst_mis", misalign_err, 0);
    chk("t6_rst_addr", imem_req_addr, 0);
    rmark = req_log.size();
    for (int i = 0; i < 20 && req_log.size() <= rmark; i++) cycle();
    if (req_log.size() > rmark) chk("t6_req_after_rst", req_log[rmark], RPC);
    else chk("t6_req_after_rst_seen", 0, 1);

    // 7: randomized traffic with redirects and occasional reset
    k_rdy = 0; k_ordy = 0; k_lat = 0;
    for (int i = 0; i < 3000; i++) begin
      k_redir = ($urandom_range(0, 19) == 0);
      k_rpc   = ($urandom_range(0, 1) == 0) ? {$urandom, 2'b00} >> 2 << 2 : 32'($urandom);
      k_rst   = ($urandom_range(0, 499) == 0);
      cycle();
    end
    k_rst = 1'b0; k_redir = 1'b0;
    repeat (10) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch front-end on the consuming side of the program counter.
- Owns the fetch PC and issues word-aligned read requests to instruction memory over a valid/ready request channel.
- Accepts the returned instruction words and buffers them, tagged with their PC, toward decode over a valid/ready output.
- Supports branch/jump redirect with flush and discard of any in-flight response; one outstanding memory request at most.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on RESET.
- FIFO_DEPTH, 2, output buffer entries; power of two, >= 2.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  request address; always [1:0]=2'b00.
- imem_rsp_valid  in  1  read data valid (one per accepted request, >= 1 cycle later).
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  branch/jump redirect strobe.
- redirect_pc  in  32  redirect target.
- out_valid  out  1  fetched instruction available.
- out_ready  in  1  decode consumes.
- out_pc  out  32  PC of out_instr.
- out_instr  out  32  instruction word.
- misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0.

Behaviour:
- Reset, sampled on posedge CLK while RESET=1:
  - pc=RESET_PC, state=IDLE, FIFO empty, drop_pending=0.
  - All outputs 0: req_valid, out_valid, out_pc, out_instr, misalign_err, imem_req_addr.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: unconditionally -> REQ next cycle.
  - REQ:
    - imem_req_valid = (fifo_count < FIFO_DEPTH); imem_req_addr = pc.
    - On req handshake: latch req_pc=pc, pc <= pc+4, -> WAIT.
    - Otherwise stay in REQ.
  - WAIT: imem_req_valid=0.
    - On imem_rsp_valid: if drop_pending=0, push {req_pc, imem_rsp_data} into the FIFO; clear drop_pending; -> REQ.
- imem_rsp_valid outside WAIT is ignored.
- Arithmetic: PC increment is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0.
- FIFO:
  - out_valid = count != 0; head drives out_pc/out_instr.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are both allowed; count unchanged.
  - Push when full cannot occur: a request issues only with space, and at most one is outstanding.
- Redirect has highest priority over all other events in its cycle:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - misalign_err=1 the next cycle if redirect_pc[1:0] != 0.
  - FIFO flushed: count=0, so out_valid=0 next cycle. A pop in the same cycle is irrelevant.
  - In REQ without handshake: stay in REQ. The next request uses the new pc.
  - In REQ with handshake in the same cycle: -> WAIT with drop_pending=1. The pc+4 update is overridden by the redirect.
  - In WAIT without rsp_valid: stay in WAIT, set drop_pending=1.
  - In WAIT with rsp_valid in the same cycle: data discarded, drop_pending=0, -> REQ.
  - Redirect while drop_pending=1: only pc is updated.
- Latency with zero-wait memory (req_ready=1, rsp one cycle after accept):
  - Cycle after RESET falls: IDLE.
  - +1: request with addr=RESET_PC.
  - +2: rsp.
  - +3: out_valid.
  - Steady throughput: 1 instruction per 2 cycles.
- RESET mid-transaction: in-flight response is discarded, since state IDLE ignores rsp_valid.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum {IDLE, REQ, WAIT}.
  - INSTR_W=32, PC_W=32, PC_INC=32'd4.
  - Struct fetch_entry_t {pc, instr}.
- Sub-module fetch_fifo:
  - Synchronous FIFO of fetch_entry_t, parameter DEPTH.
  - Ports: push, pop, flush, full, empty, count, head.
  - Same CLK/RESET conventions.

Test Plan:
- Zero-wait memory, out_ready=1, 6 fetches after reset → requests at 0x0, 0x4, …, 0x14. out_pc/out_instr match memory image; first out_valid 3 cycles after reset release.
- out_ready=0 for 10 cycles → exactly 2 entries (PCs 0x0, 0x4) buffered. No 3rd req_valid. Releasing out_ready drains in order, then fetch resumes at 0x8.
- imem_req_ready low for 4 cycles at addr 0x8 → req_valid and addr held at 0x8 stable. pc does not advance until the handshake.
- Redirect to 0x100 while WAIT for addr 0xC with 3-cycle rsp latency → 0xC data never appears on out. FIFO empties; next request is 0x100.
- Redirect to 0x203 coincident with rsp_valid → misalign_err pulses one cycle. Response dropped; next request at 0x200.
- Redirect to 0xFFFF_FFFC with zero-wait memory → output PCs 0xFFFF_FFFC then 0x0000_0000 (wrap). RESET asserted mid-WAIT → outputs 0; first new request at RESET_PC.
